// File: rtl/rs_generic_pkg.sv
`default_nettype none
// =============================================================================
// rs_generic_pkg : shared types for the generic reservation station
// Revision       : 1.0
// =============================================================================
package rs_generic_pkg;

    localparam int PREG_IDX_W = 6;
    localparam int ROB_IDX_W  = 5;
    localparam int OPCODE_W   = 7;

    localparam logic [PREG_IDX_W-1:0] ZERO_REG = '0;

    typedef enum logic [2:0] {
        FU_ALU    = 3'd0,
        FU_MULT   = 3'd1,
        FU_LOAD   = 3'd2,
        FU_STORE  = 3'd3,
        FU_BRANCH = 3'd4
    } FU_TYPE;

    typedef struct packed {
        logic [PREG_IDX_W-1:0] num;
        logic                  ready;
    } REG;

    typedef struct packed {
        FU_TYPE                fu;
        REG                    tag1;
        REG                    tag2;
        logic [ROB_IDX_W-1:0]  rob_idx;
        logic [OPCODE_W-1:0]   opcode;
    } RS_PACKET;

endpackage

`default_nettype wire

// File: rtl/rs_generic_age_select.sv
`default_nettype none
// =============================================================================
// rs_age_select : allocation-age matrix and oldest-ready one-hot selector
// Revision      : 1.0
// =============================================================================
module rs_age_select #(
    parameter  int RS_SIZE = 8,
    localparam int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               squash,
    input  logic [RS_SIZE-1:0] busy,
    input  logic [RS_SIZE-1:0] candidate,
    input  logic               alloc_en,
    input  logic [IDX_W-1:0]   alloc_idx,
    input  logic               free_en,
    input  logic [IDX_W-1:0]   free_idx,
    output logic               sel_valid,
    output logic [RS_SIZE-1:0] sel_onehot,
    output logic [IDX_W-1:0]   sel_idx
);

    // older[i][j] = 1 : entry i was allocated before entry j
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older_col;

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            older <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                for (int j = 0; j < RS_SIZE; j++) begin
                    if (free_en && (i == int'(free_idx) || j == int'(free_idx)))
                        older[i][j] <= 1'b0;
                    else if (alloc_en && i == int'(alloc_idx))
                        older[i][j] <= 1'b0;
                    else if (alloc_en && j == int'(alloc_idx))
                        older[i][j] <= busy[i];
                end
            end
        end
    end

    // An entry wins when no other candidate is older than it
    for (genvar i = 0; i < RS_SIZE; i++) begin : g_sel
        for (genvar j = 0; j < RS_SIZE; j++) begin : g_col
            assign older_col[i][j] = older[j][i];
        end
        assign sel_onehot[i] = candidate[i] && !(|(candidate & older_col[i]));
    end

    assign sel_valid = |candidate;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (sel_onehot[i]) sel_idx = sel_idx | IDX_W'(i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rs_generic.sv
`default_nettype none
// =============================================================================
// rs_generic : unified reservation station with multi-CDB wakeup and
//              oldest-ready issue over a valid/ready port
// Revision   : 1.0
// =============================================================================
module rs_generic #(
    parameter  int RS_SIZE    = 8,
    parameter  int CDB_WIDTH  = 2,
    parameter  int PREG_IDX_W = rs_generic_pkg::PREG_IDX_W,
    localparam int IDX_W      = $clog2(RS_SIZE),
    localparam int CNT_W      = $clog2(RS_SIZE + 1)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 alloc_valid,
    input  rs_generic_pkg::RS_PACKET             alloc_packet,
    output logic                                 alloc_ready,
    input  logic [CDB_WIDTH-1:0]                 cdb_valid,
    input  logic [CDB_WIDTH-1:0][PREG_IDX_W-1:0] cdb_tag,
    output logic                                 issue_valid,
    output rs_generic_pkg::RS_PACKET             issue_packet,
    input  logic                                 issue_ready,
    output logic [IDX_W-1:0]                     issue_idx,
    input  logic                                 squash,
    output logic [CNT_W-1:0]                     free_count
);

    import rs_generic_pkg::*;

    logic [RS_SIZE-1:0] busy;
    RS_PACKET           entries [RS_SIZE];

    logic [RS_SIZE-1:0] candidate;
    logic [RS_SIZE-1:0] sel_onehot;
    logic [RS_SIZE-1:0] wake1;
    logic [RS_SIZE-1:0] wake2;
    logic [IDX_W-1:0]   alloc_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic               alloc_fire;
    logic               issue_fire;
    RS_PACKET           alloc_stored;

    function automatic logic cdb_hit(
        input logic [PREG_IDX_W-1:0]                 num,
        input logic [CDB_WIDTH-1:0]                  valid,
        input logic [CDB_WIDTH-1:0][PREG_IDX_W-1:0]  tags
    );
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_WIDTH; c++) begin
            if (valid[c] && tags[c] == num) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        alloc_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_idx = IDX_W'(i);
        end
    end

    assign alloc_ready = ~&busy;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign issue_fire  = sel_valid && issue_ready;

    for (genvar i = 0; i < RS_SIZE; i++) begin : g_entry
        assign candidate[i] = busy[i] && entries[i].tag1.ready && entries[i].tag2.ready;
        assign wake1[i]     = busy[i] && cdb_hit(entries[i].tag1.num, cdb_valid, cdb_tag);
        assign wake2[i]     = busy[i] && cdb_hit(entries[i].tag2.num, cdb_valid, cdb_tag);
    end

    // Incoming tags see this cycle's broadcasts so no wakeup is lost in flight
    always_comb begin
        alloc_stored            = alloc_packet;
        alloc_stored.tag1.ready = alloc_packet.tag1.ready || (alloc_packet.tag1.num == ZERO_REG)
                                  || cdb_hit(alloc_packet.tag1.num, cdb_valid, cdb_tag);
        alloc_stored.tag2.ready = alloc_packet.tag2.ready || (alloc_packet.tag2.num == ZERO_REG)
                                  || cdb_hit(alloc_packet.tag2.num, cdb_valid, cdb_tag);
    end

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            busy <= '0;
            for (int i = 0; i < RS_SIZE; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (wake1[i]) entries[i].tag1.ready <= 1'b1;
                if (wake2[i]) entries[i].tag2.ready <= 1'b1;
                if (issue_fire && sel_onehot[i]) busy[i] <= 1'b0;
                if (alloc_fire && alloc_idx == IDX_W'(i)) begin
                    busy[i]    <= 1'b1;
                    entries[i] <= alloc_stored;
                end
            end
        end
    end

    rs_age_select #(
        .RS_SIZE (RS_SIZE)
    ) u_age_select (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .busy       (busy),
        .candidate  (candidate),
        .alloc_en   (alloc_fire),
        .alloc_idx  (alloc_idx),
        .free_en    (issue_fire),
        .free_idx   (sel_idx),
        .sel_valid  (sel_valid),
        .sel_onehot (sel_onehot),
        .sel_idx    (sel_idx)
    );

    always_comb begin
        issue_packet = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (sel_onehot[i]) issue_packet = entries[i];
        end
    end

    assign issue_valid = sel_valid;
    assign issue_idx   = sel_idx;

    always_comb begin
        free_count = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!busy[i]) free_count = free_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_generic.sv
`default_nettype none
// =============================================================================
// tb_rs_generic : scenario and randomized checks of rs_generic against an
//                 allocation-stamp reference model
// Revision      : 1.0
// =============================================================================
module tb_rs_generic;

    import rs_generic_pkg::*;

    localparam int N  = 8;
    localparam int CW = 2;

    logic                            clock = 1'b0;
    logic                            reset;
    logic                            alloc_valid;
    RS_PACKET                        alloc_packet;
    logic                            alloc_ready;
    logic [CW-1:0]                   cdb_valid;
    logic [CW-1:0][PREG_IDX_W-1:0]   cdb_tag;
    logic                            issue_valid;
    RS_PACKET                        issue_packet;
    logic                            issue_ready;
    logic [2:0]                      issue_idx;
    logic                            squash;
    logic [3:0]                      free_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rs_generic #(
        .RS_SIZE    (N),
        .CDB_WIDTH  (CW),
        .PREG_IDX_W (PREG_IDX_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_valid  (alloc_valid),
        .alloc_packet (alloc_packet),
        .alloc_ready  (alloc_ready),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .issue_valid  (issue_valid),
        .issue_packet (issue_packet),
        .issue_ready  (issue_ready),
        .issue_idx    (issue_idx),
        .squash       (squash),
        .free_count   (free_count)
    );

    // Reference model: each occupied slot carries an allocation stamp; the
    // oldest ready slot is the one with the smallest stamp.
    bit       m_busy  [N];
    RS_PACKET m_pkt   [N];
    int       m_stamp [N];
    int       m_next_stamp = 0;

    function automatic bit m_hit(input logic [PREG_IDX_W-1:0] num);
        for (int c = 0; c < CW; c++)
            if (cdb_valid[c] && cdb_tag[c] == num) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_oldest_ready();
        int best = -1;
        for (int i = 0; i < N; i++)
            if (m_busy[i] && m_pkt[i].tag1.ready && m_pkt[i].tag2.ready)
                if (best < 0 || m_stamp[i] < m_stamp[best]) best = i;
        return best;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic int m_free_slots();
        int n = 0;
        for (int i = 0; i < N; i++) if (!m_busy[i]) n++;
        return n;
    endfunction

    task automatic model_edge();
        int       sel;
        int       a;
        RS_PACKET p;
        if (reset || squash) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            return;
        end
        sel = m_oldest_ready();
        a   = m_lowest_free();
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && m_hit(m_pkt[i].tag1.num)) m_pkt[i].tag1.ready = 1'b1;
            if (m_busy[i] && m_hit(m_pkt[i].tag2.num)) m_pkt[i].tag2.ready = 1'b1;
        end
        if (sel >= 0 && issue_ready) m_busy[sel] = 1'b0;
        if (alloc_valid && a >= 0) begin
            p = alloc_packet;
            if (p.tag1.num == '0 || m_hit(p.tag1.num)) p.tag1.ready = 1'b1;
            if (p.tag2.num == '0 || m_hit(p.tag2.num)) p.tag2.ready = 1'b1;
            m_pkt[a]   = p;
            m_busy[a]  = 1'b1;
            m_stamp[a] = m_next_stamp;
            m_next_stamp++;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alloc_valid  = 1'b0;
        alloc_packet = '0;
        cdb_valid    = '0;
        cdb_tag      = '0;
        issue_ready  = 1'b0;
        squash       = 1'b0;
    endtask

    function automatic RS_PACKET mk(input int n1, input bit r1, input int n2, input bit r2);
        RS_PACKET p;
        p.fu         = FU_TYPE'(3'($urandom_range(0, 4)));
        p.tag1.num   = PREG_IDX_W'(n1);
        p.tag1.ready = r1;
        p.tag2.num   = PREG_IDX_W'(n2);
        p.tag2.ready = r2;
        p.rob_idx    = ROB_IDX_W'($urandom);
        p.opcode     = OPCODE_W'($urandom);
        return p;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %b want 1", alloc_ready); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
        checks++; if (issue_idx !== 3'd0) begin errors++; $display("FAIL reset_issue_idx got %0d want 0", issue_idx); end
        checks++; if (issue_packet !== RS_PACKET'('0)) begin errors++; $display("FAIL reset_issue_packet got %h want 0", issue_packet); end
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL reset_free_count got %0d want 8", free_count); end
    endtask

    task automatic test_in_order();
        RS_PACKET p [3];
        for (int k = 0; k < 3; k++) begin
            p[k]         = mk(k + 1, 1'b1, k + 11, 1'b1);
            alloc_packet = p[k];
            alloc_valid  = 1'b1;
            tick();
        end
        idle();
        issue_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL order_valid[%0d] got %b want 1", k, issue_valid); end
            checks++; if (issue_idx !== 3'(k)) begin errors++; $display("FAIL order_idx[%0d] got %0d want %0d", k, issue_idx, k); end
            checks++; if (issue_packet !== p[k]) begin errors++; $display("FAIL order_packet[%0d] got %h want %h", k, issue_packet, p[k]); end
            tick();
        end
        issue_ready = 1'b0;
        #1;
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL order_free_count got %0d want 8", free_count); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL order_drained got %b want 0", issue_valid); end
    endtask

    task automatic test_wakeup_latency();
        alloc_packet = mk(5, 1'b0, 0, 1'b0);
        alloc_valid  = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_pending got %b want 0", issue_valid); end
        cdb_valid  = 2'b01;
        cdb_tag[0] = 6'd5;
        cdb_tag[1] = 6'd7;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_same_cycle got %b want 0", issue_valid); end
        tick();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL wake_next_cycle got %b want 1", issue_valid); end
        checks++; if (issue_idx !== 3'd0) begin errors++; $display("FAIL wake_idx got %0d want 0", issue_idx); end
        checks++; if (issue_packet.tag1.ready !== 1'b1 || issue_packet.tag2.ready !== 1'b1) begin
            errors++; $display("FAIL wake_tags_ready got %b%b want 11", issue_packet.tag1.ready, issue_packet.tag2.ready);
        end
        issue_ready = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        alloc_packet = mk(12, 1'b1, 9, 1'b0);
        alloc_valid  = 1'b1;
        cdb_valid    = 2'b10;
        cdb_tag[0]   = 6'd3;
        cdb_tag[1]   = 6'd9;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL bypass_same_cycle got %b want 0", issue_valid); end
        tick();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL bypass_next_cycle got %b want 1", issue_valid); end
        checks++; if (issue_packet.tag2.ready !== 1'b1) begin errors++; $display("FAIL bypass_tag2_ready got %b want 1", issue_packet.tag2.ready); end
        checks++; if (issue_packet.tag1.num !== 6'd12) begin errors++; $display("FAIL bypass_tag1_num got %0d want 12", issue_packet.tag1.num); end
        issue_ready = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_full();
        RS_PACKET q [N];
        RS_PACKET nw;
        for (int k = 0; k < N; k++) begin
            q[k]         = mk(k + 20, 1'b1, k + 40, 1'b1);
            alloc_packet = q[k];
            alloc_valid  = 1'b1;
            tick();
        end
        alloc_packet = mk(1, 1'b1, 2, 1'b1);
        #1;
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_alloc_ready got %b want 0", alloc_ready); end
        checks++; if (free_count !== 4'd0) begin errors++; $display("FAIL full_free_count got %0d want 0", free_count); end
        checks++; if (issue_idx !== 3'd0) begin errors++; $display("FAIL full_oldest got %0d want 0", issue_idx); end
        issue_ready = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL full_reopen got %b want 1", alloc_ready); end
        checks++; if (free_count !== 4'd1) begin errors++; $display("FAIL full_one_free got %0d want 1", free_count); end
        nw           = mk(50, 1'b1, 51, 1'b1);
        alloc_packet = nw;
        alloc_valid  = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (free_count !== 4'd0) begin errors++; $display("FAIL full_refill got %0d want 0", free_count); end
        issue_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            #1;
            checks++; if (issue_idx !== 3'((k + 1) % N)) begin
                errors++; $display("FAIL full_drain_idx[%0d] got %0d want %0d", k, issue_idx, (k + 1) % N);
            end
            checks++; if (issue_packet !== ((k < N - 1) ? q[k + 1] : nw)) begin
                errors++; $display("FAIL full_drain_packet[%0d] got %h", k, issue_packet);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_hold_switch();
        for (int k = 0; k < 4; k++) begin
            alloc_packet = mk(30 + k, 1'b0, 0, 1'b1);
            alloc_valid  = 1'b1;
            tick();
        end
        alloc_packet = mk(40, 1'b1, 41, 1'b1);
        tick();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd4) begin
            errors++; $display("FAIL hold_present got v=%b idx=%0d want v=1 idx=4", issue_valid, issue_idx);
        end
        cdb_valid  = 2'b01;
        cdb_tag[0] = 6'd32;
        #1;
        checks++; if (issue_idx !== 3'd4) begin errors++; $display("FAIL hold_same_cycle got %0d want 4", issue_idx); end
        tick();
        idle();
        #1;
        checks++; if (issue_idx !== 3'd2) begin errors++; $display("FAIL hold_switch got %0d want 2", issue_idx); end
        checks++; if (free_count !== 4'd3) begin errors++; $display("FAIL hold_still_busy got %0d want 3", free_count); end
    endtask

    task automatic test_squash();
        squash       = 1'b1;
        alloc_valid  = 1'b1;
        alloc_packet = mk(1, 1'b1, 2, 1'b1);
        cdb_valid    = 2'b01;
        cdb_tag[0]   = 6'd30;
        issue_ready  = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (free_count !== 4'd8) begin errors++; $display("FAIL squash_free_count got %0d want 8", free_count); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL squash_issue_valid got %b want 0", issue_valid); end
        alloc_packet = mk(3, 1'b1, 4, 1'b1);
        alloc_valid  = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (issue_idx !== 3'd0 || free_count !== 4'd7) begin
            errors++; $display("FAIL squash_realloc got idx=%0d free=%0d want idx=0 free=7", issue_idx, free_count);
        end
        issue_ready = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_random();
        int sel;
        for (int cyc = 0; cyc < 600; cyc++) begin
            alloc_valid  = ($urandom_range(0, 3) != 0);
            alloc_packet = mk($urandom_range(0, 15), 1'($urandom), $urandom_range(0, 15), 1'($urandom));
            cdb_valid    = CW'($urandom);
            for (int c = 0; c < CW; c++) cdb_tag[c] = PREG_IDX_W'($urandom_range(0, 15));
            issue_ready  = ((cyc % 128) < 64) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            squash       = ($urandom_range(0, 59) == 0);
            reset        = (cyc == 300);
            #1;
            sel = m_oldest_ready();
            checks++; if (alloc_ready !== (m_free_slots() != 0)) begin
                errors++; $display("FAIL rand_alloc_ready cyc %0d got %b want %b", cyc, alloc_ready, m_free_slots() != 0);
            end
            checks++; if (free_count !== 4'(m_free_slots())) begin
                errors++; $display("FAIL rand_free_count cyc %0d got %0d want %0d", cyc, free_count, m_free_slots());
            end
            checks++; if (issue_valid !== (sel >= 0)) begin
                errors++; $display("FAIL rand_issue_valid cyc %0d got %b want %b", cyc, issue_valid, sel >= 0);
            end
            if (sel >= 0) begin
                checks++; if (issue_idx !== 3'(sel)) begin
                    errors++; $display("FAIL rand_issue_idx cyc %0d got %0d want %0d", cyc, issue_idx, sel);
                end
                checks++; if (issue_packet !== m_pkt[sel]) begin
                    errors++; $display("FAIL rand_issue_packet cyc %0d got %h want %h", cyc, issue_packet, m_pkt[sel]);
                end
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_in_order();
        test_wakeup_latency();
        test_bypass();
        test_full();
        test_hold_switch();
        test_squash();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

`default_nettype wire
